// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, state encoding and line types for the cacheline adapter
// Purpose: common localparams, the adapter state enum, line/beat types and an
//          address line-alignment helper shared by cacheline_adapter and line_buffer.
// Ports:   none (package)
package cache_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int ADDR_W   = 32;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    AD_IDLE,
    AD_RD,
    AD_WR,
    AD_DONE
  } adapter_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [CNT_W-1:0]  beat_idx_t;

  // Clear the byte-offset bits so every burst starts on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << OFFSET_W) - 1);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one cacheline register with parallel load and beat-indexed access
// Purpose: holds a full line; can be loaded whole, or written/read one burst beat at a time.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low clear
//   i_load       load the whole line from i_load_data (wins over a beat write)
//   i_load_data  full line to load
//   i_beat_we    write i_beat_data into the beat selected by i_beat_idx
//   i_beat_idx   beat select for both write and read mux
//   i_beat_data  beat write data
//   o_beat_data  beat currently selected by i_beat_idx
//   o_line       full stored line
module line_buffer
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  line_t              i_load_data,
  input  logic               i_beat_we,
  input  beat_idx_t          i_beat_idx,
  input  logic [BURST_W-1:0] i_beat_data,
  output logic [BURST_W-1:0] o_beat_data,
  output line_t              o_line
);

  line_t r_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_load_data;
    end else if (i_beat_we) begin
      r_line[int'(i_beat_idx)*BURST_W +: BURST_W] <= i_beat_data;
    end
  end

  assign o_beat_data = r_line[int'(i_beat_idx)*BURST_W +: BURST_W];
  assign o_line      = r_line;

endmodule

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - converts one cacheline read/write into a 4-beat memory burst
// Purpose: accepts a held line read or write from the arbiter, runs a BEATS-long burst
//          on the memory bus (one beat per mem_resp), then pulses o_line_resp once.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_line_read, i_line_write      arbiter requests, held until o_line_resp (read wins)
//   i_line_addr, i_line_wdata      request address and write line, latched on acceptance
//   o_line_rdata                   assembled read line, valid in the completion cycle
//   o_line_resp                    one-cycle completion pulse
//   o_mem_read, o_mem_write        burst requests, high for the whole burst
//   o_mem_addr                     line-aligned burst address
//   o_mem_wdata                    current write beat
//   i_mem_rdata, i_mem_resp        current read beat and per-beat acknowledge
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_line_read,
  input  logic               i_line_write,
  input  logic [ADDR_W-1:0]  i_line_addr,
  input  line_t              i_line_wdata,
  output line_t              o_line_rdata,
  output logic               o_line_resp,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [BURST_W-1:0] o_mem_wdata,
  input  logic [BURST_W-1:0] i_mem_rdata,
  input  logic               i_mem_resp
);

  adapter_state_t    r_state;
  beat_idx_t         r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;

  logic               w_accept;
  logic               w_rd_beat;
  logic               w_last_beat;
  line_t              w_unused_wbuf_line;
  logic [BURST_W-1:0] w_unused_rbuf_beat;

  assign w_accept    = (r_state == AD_IDLE) && (i_line_read || i_line_write);
  assign w_rd_beat   = (r_state == AD_RD) && i_mem_resp;
  assign w_last_beat = (r_cnt == beat_idx_t'(BEATS - 1));

  // mem_resp only matters in RD/WR; IDLE and DONE ignore it. DONE always returns to
  // IDLE without looking at the request, so a held request cannot be issued twice.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= AD_IDLE;
      r_cnt      <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        AD_IDLE: begin
          if (w_accept) begin
            r_state    <= i_line_read ? AD_RD : AD_WR;
            r_mem_addr <= line_align(i_line_addr);
            r_cnt      <= '0;
          end
        end
        AD_RD, AD_WR: begin
          if (i_mem_resp) begin
            r_cnt <= r_cnt + 1'b1;  // wraps to 0 after the last beat
            if (w_last_beat) begin
              r_state <= AD_DONE;
            end
          end
        end
        AD_DONE: r_state <= AD_IDLE;
        default: r_state <= AD_IDLE;
      endcase
    end
  end

  // Write data is latched whenever a request is accepted, so later line_wdata
  // changes cannot leak into the burst.
  line_buffer u_wbuf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_accept),
    .i_load_data (i_line_wdata),
    .i_beat_we   (1'b0),
    .i_beat_idx  (r_cnt),
    .i_beat_data ('0),
    .o_beat_data (o_mem_wdata),
    .o_line      (w_unused_wbuf_line)
  );

  // Read line lives in its own buffer so write bursts never disturb o_line_rdata.
  line_buffer u_rbuf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_beat_we   (w_rd_beat),
    .i_beat_idx  (r_cnt),
    .i_beat_data (i_mem_rdata),
    .o_beat_data (w_unused_rbuf_beat),
    .o_line      (o_line_rdata)
  );

  assign o_mem_read  = (r_state == AD_RD);
  assign o_mem_write = (r_state == AD_WR);
  assign o_line_resp = (r_state == AD_DONE);
  assign o_mem_addr  = r_mem_addr;

endmodule
